// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update path: PHT counter encoding,
// update-scheduler states and the queued update record.
package bp_pkg;

  localparam int BP_BHR_W = 8;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } p_state_t;

  typedef enum logic [1:0] {INIT, IDLE, DRAIN, RECOVER} sched_state_t;

  typedef struct packed {
    logic [BP_BHR_W-1:0] idx;
    logic                taken;
  } br_upd_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// In-order update FIFO: up to two writes and one read per cycle, with flush.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic [1:0]             i_wr_n,
  input  br_upd_t                i_wr_d0,
  input  br_upd_t                i_wr_d1,
  input  logic                   i_pop,
  output br_upd_t                o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW-1:0] w_wp1;
  br_upd_t       r_mem [DEPTH];

  // Pointers carry a wrap bit: equal means empty, MSB-only difference means full.
  assign w_wp1   = r_wp + PW'(1);
  assign o_head  = r_mem[r_rp[AW-1:0]];
  assign o_count = r_wp - r_rp;
  assign o_empty = (r_wp == r_rp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_flush) begin
      r_rp <= r_wp;
    end else begin
      r_wp <= r_wp + PW'(i_wr_n);
      if (i_pop) r_rp <= r_rp + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_flush) begin
      if (i_wr_n != 2'd0) r_mem[r_wp[AW-1:0]]  <= i_wr_d0;
      if (i_wr_n == 2'd2) r_mem[w_wp1[AW-1:0]] <= i_wr_d1;
    end
  end

endmodule

// File: rtl/bp_update_sched.sv
// PHT write-port scheduler: init sweep, in-order training drain, BHR recovery.
// Optional macro BP_UPD_SCHED_STATS_EN adds training/recovery event counters.
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int BHR_W   = BP_BHR_W,
  parameter int PHT_NUM = 2**BHR_W,
  parameter int Q_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br0_valid_i,
  output logic             br0_ready_o,
  input  logic [BHR_W-1:0] br0_idx_i,
  input  logic             br0_taken_i,
  input  logic             br0_mispred_i,
  input  logic             br1_valid_i,
  output logic             br1_ready_o,
  input  logic [BHR_W-1:0] br1_idx_i,
  input  logic             br1_taken_i,
  input  logic             br1_mispred_i,
  input  logic             flush_i,
  output logic             pht_we_o,
  output logic [BHR_W-1:0] pht_widx_o,
  output logic             pht_wtaken_o,
  output logic             pht_init_o,
  output logic             rcv_valid_o,
  output logic [BHR_W-1:0] rcv_bhr_o,
  output logic             rcv_taken_o,
  output logic             busy_o
`ifdef BP_UPD_SCHED_STATS_EN
  ,
  output logic [31:0]      stat_upd_o,
  output logic [31:0]      stat_mis_o
`endif
);

  // state   | meaning
  // INIT    | sweeping every PHT entry to WEAK_NT
  // IDLE    | queue empty, no write
  // DRAIN   | one queued update written to the PHT
  // RECOVER | BHR recovery strobe, PHT port held off

  localparam int               CW         = $clog2(Q_DEPTH) + 1;
  localparam logic [BHR_W-1:0] SWEEP_LAST = BHR_W'(PHT_NUM - 1);
  localparam logic [CW-1:0]    READY_MAX  = CW'(Q_DEPTH - 2);

  sched_state_t     r_state, w_state_nxt;
  logic [BHR_W-1:0] r_sweep, w_sweep_nxt;
  logic             r_we, r_wtaken, r_init, r_rcv_valid, r_rcv_taken, r_ready, r_busy;
  logic [BHR_W-1:0] r_widx, r_rcv_bhr;

  logic             w_acc0, w_acc1, w_mis0, w_mis1, w_mis;
  br_upd_t          w_br0, w_br1, w_in_a, w_in_b, w_rcv;
  logic [1:0]       w_in_n;
  logic             w_we, w_wtaken, w_init;
  logic [BHR_W-1:0] w_widx;
  logic             w_f_flush, w_f_pop, w_f_empty;
  logic [1:0]       w_f_wr_n;
  br_upd_t          w_f_d0, w_f_d1, w_f_head;
  logic [CW-1:0]    w_f_count, w_cnt_nxt;

  assign w_acc0 = br0_valid_i & br0_ready_o;
  assign w_acc1 = br1_valid_i & br1_ready_o;
  assign w_mis0 = w_acc0 & br0_mispred_i;
  assign w_mis1 = w_acc1 & br1_mispred_i;
  assign w_mis  = w_mis0 | w_mis1;
  assign w_br0  = {br0_idx_i, br0_taken_i};
  assign w_br1  = {br1_idx_i, br1_taken_i};
  assign w_in_a = w_acc0 ? w_br0 : w_br1;
  assign w_in_b = w_br1;
  assign w_in_n = {1'b0, w_acc0} + {1'b0, w_acc1};
  assign w_rcv  = w_mis0 ? w_br0 : w_br1;

  bp_upd_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_f_flush),
    .i_wr_n  (w_f_wr_n),
    .i_wr_d0 (w_f_d0),
    .i_wr_d1 (w_f_d1),
    .i_pop   (w_f_pop),
    .o_head  (w_f_head),
    .o_count (w_f_count),
    .o_empty (w_f_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_we        = 1'b0;
    w_init      = 1'b0;
    w_widx      = '0;
    w_wtaken    = 1'b0;
    w_f_flush   = 1'b0;
    w_f_pop     = 1'b0;
    w_f_wr_n    = 2'd0;
    w_f_d0      = w_in_a;
    w_f_d1      = w_in_b;
    w_cnt_nxt   = w_f_count;
    case (r_state)
      INIT: begin
        w_we        = 1'b1;
        w_init      = 1'b1;
        w_widx      = r_sweep;
        w_sweep_nxt = r_sweep + BHR_W'(1);
        if (r_sweep == SWEEP_LAST) w_state_nxt = IDLE;
      end
      default: begin
        if (flush_i) begin
          w_f_flush   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (w_mis) begin
          w_f_wr_n    = w_in_n;
          w_cnt_nxt   = w_f_count + CW'(w_in_n);
          w_state_nxt = RECOVER;
        end else if (!w_f_empty) begin
          w_we        = 1'b1;
          w_widx      = w_f_head.idx;
          w_wtaken    = w_f_head.taken;
          w_f_pop     = 1'b1;
          w_f_wr_n    = w_in_n;
          w_cnt_nxt   = w_f_count + CW'(w_in_n) - CW'(1);
          w_state_nxt = DRAIN;
        end else if (w_in_n != 2'd0) begin
          // Empty queue: the oldest arriving update bypasses straight to the write port.
          w_we        = 1'b1;
          w_widx      = w_in_a.idx;
          w_wtaken    = w_in_a.taken;
          w_f_d0      = w_in_b;
          w_f_wr_n    = w_in_n - 2'd1;
          w_cnt_nxt   = CW'(w_in_n - 2'd1);
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= INIT;
      r_sweep     <= '0;
      r_we        <= 1'b0;
      r_widx      <= '0;
      r_wtaken    <= 1'b0;
      r_init      <= 1'b0;
      r_rcv_valid <= 1'b0;
      r_rcv_bhr   <= '0;
      r_rcv_taken <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep     <= w_sweep_nxt;
      r_we        <= w_we;
      r_widx      <= w_widx;
      r_wtaken    <= w_wtaken;
      r_init      <= w_init;
      r_rcv_valid <= w_mis;
      r_rcv_bhr   <= w_mis ? w_rcv.idx : '0;
      r_rcv_taken <= w_mis & w_rcv.taken;
      r_ready     <= !w_init && (w_cnt_nxt <= READY_MAX);
      r_busy      <= w_init || (w_cnt_nxt != '0);
    end
  end

  assign br0_ready_o  = r_ready;
  assign br1_ready_o  = r_ready;
  assign pht_we_o     = r_we;
  assign pht_widx_o   = r_widx;
  assign pht_wtaken_o = r_wtaken;
  assign pht_init_o   = r_init;
  assign rcv_valid_o  = r_rcv_valid;
  assign rcv_bhr_o    = r_rcv_bhr;
  assign rcv_taken_o  = r_rcv_taken;
  assign busy_o       = r_busy;

`ifdef BP_UPD_SCHED_STATS_EN
  logic [31:0] r_stat_upd, r_stat_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_upd <= '0;
      r_stat_mis <= '0;
    end else begin
      if (w_we && !w_init) r_stat_upd <= r_stat_upd + 32'd1;
      if (w_mis)           r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign stat_upd_o = r_stat_upd;
  assign stat_mis_o = r_stat_mis;
`endif

endmodule

// File: tb/tb_bp_update_sched.sv
// Scoreboard bench for bp_update_sched: accepted updates feed an age-ordered
// expectation queue; a negedge monitor checks every write/recovery it presents.
module tb_bp_update_sched;
  import bp_pkg::*;

  localparam int BHR_W   = 8;
  localparam int PHT_NUM = 256;
  localparam int Q_DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             br0_valid_i = 1'b0, br0_taken_i = 1'b0, br0_mispred_i = 1'b0, br0_ready_o;
  logic             br1_valid_i = 1'b0, br1_taken_i = 1'b0, br1_mispred_i = 1'b0, br1_ready_o;
  logic [BHR_W-1:0] br0_idx_i = '0, br1_idx_i = '0;
  logic             flush_i = 1'b0;
  logic             pht_we_o, pht_wtaken_o, pht_init_o, rcv_valid_o, rcv_taken_o, busy_o;
  logic [BHR_W-1:0] pht_widx_o, rcv_bhr_o;
`ifdef BP_UPD_SCHED_STATS_EN
  logic [31:0]      stat_upd_o, stat_mis_o;
`endif

  bp_update_sched #(.BHR_W(BHR_W), .PHT_NUM(PHT_NUM), .Q_DEPTH(Q_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .br0_valid_i(br0_valid_i), .br0_ready_o(br0_ready_o), .br0_idx_i(br0_idx_i),
    .br0_taken_i(br0_taken_i), .br0_mispred_i(br0_mispred_i),
    .br1_valid_i(br1_valid_i), .br1_ready_o(br1_ready_o), .br1_idx_i(br1_idx_i),
    .br1_taken_i(br1_taken_i), .br1_mispred_i(br1_mispred_i),
    .flush_i(flush_i),
    .pht_we_o(pht_we_o), .pht_widx_o(pht_widx_o), .pht_wtaken_o(pht_wtaken_o),
    .pht_init_o(pht_init_o),
    .rcv_valid_o(rcv_valid_o), .rcv_bhr_o(rcv_bhr_o), .rcv_taken_o(rcv_taken_o),
    .busy_o(busy_o)
`ifdef BP_UPD_SCHED_STATS_EN
    , .stat_upd_o(stat_upd_o), .stat_mis_o(stat_mis_o)
`endif
  );

  always #5 clk = ~clk;

  logic [8:0] exp_q[$];
  logic [8:0] rcv_q[$];
  logic [8:0] mon_e;
  int n_checks = 0;
  int n_fail = 0;
  int exp_sweep = 0;
  int n_trained = 0;
  int n_rcv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: accepted updates queue in age order (port 0 first);
  // the oldest mispredict in a cycle is the expected recovery.
  always @(posedge clk) begin
    if (!rst) begin
      if (flush_i && !pht_init_o) begin
        exp_q.delete();
      end else begin
        if (br0_valid_i && br0_ready_o) exp_q.push_back({br0_idx_i, br0_taken_i});
        if (br1_valid_i && br1_ready_o) exp_q.push_back({br1_idx_i, br1_taken_i});
        if (br0_valid_i && br0_ready_o && br0_mispred_i)
          rcv_q.push_back({br0_idx_i, br0_taken_i});
        else if (br1_valid_i && br1_ready_o && br1_mispred_i)
          rcv_q.push_back({br1_idx_i, br1_taken_i});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (pht_we_o && pht_init_o) begin
        chk("sweep_idx", 32'(pht_widx_o), exp_sweep);
        exp_sweep++;
      end else if (pht_we_o) begin
        chk("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("write_entry", {pht_widx_o, pht_wtaken_o}, mon_e);
          n_trained++;
        end
      end
      if (rcv_valid_o) begin
        chk("rcv_no_write", pht_we_o, 0);
        chk("rcv_expected", 32'(rcv_q.size() != 0), 1);
        if (rcv_q.size() != 0) begin
          mon_e = rcv_q.pop_front();
          chk("rcv_entry", {rcv_bhr_o, rcv_taken_o}, mon_e);
          n_rcv++;
        end
      end
      if (pht_init_o || exp_sweep < PHT_NUM) begin
        chk("ready_init", {br0_ready_o, br1_ready_o}, 0);
        chk("busy_init", busy_o, 1);
      end else begin
        chk("ready", {br0_ready_o, br1_ready_o}, (exp_q.size() <= Q_DEPTH - 2) ? 2'b11 : 2'b00);
        chk("busy", busy_o, 32'(exp_q.size() != 0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br0_valid_i = 1'b0; br0_mispred_i = 1'b0;
    br1_valid_i = 1'b0; br1_mispred_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic set_br(input logic v0, input logic [7:0] i0, input logic t0, input logic m0,
                        input logic v1, input logic [7:0] i1, input logic t1, input logic m1);
    br0_valid_i = v0; br0_idx_i = i0; br0_taken_i = t0; br0_mispred_i = m0;
    br1_valid_i = v1; br1_idx_i = i1; br1_taken_i = t1; br1_mispred_i = m1;
  endtask

  task automatic wait_sweep();
    for (int i = 0; i < 400 && !(exp_sweep == PHT_NUM && !pht_init_o); i++) step();
    chk("sweep_len", exp_sweep, PHT_NUM);
    chk("sweep_over", pht_init_o, 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (exp_q.size() != 0 || rcv_q.size() != 0); i++) step();
    chk("drained", exp_q.size() + rcv_q.size(), 0);
    step();
  endtask

  logic saw_low;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Sweep, with a flush in the middle that must be ignored.
    repeat (20) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    wait_sweep();

    // Two updates in one cycle: older one written the next cycle, then the younger.
    set_br(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("lat_first", {pht_we_o, pht_widx_o, pht_wtaken_o}, {1'b1, 8'h3C, 1'b1});
    @(negedge clk);
    chk("lat_second", {pht_we_o, pht_widx_o, pht_wtaken_o}, {1'b1, 8'h11, 1'b0});
    step();
    wait_drain();

    // Back-to-back pairs until ready throttles.
    saw_low = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!br0_ready_o) saw_low = 1'b1;
      set_br(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b1, 8'($urandom), 1'($urandom), 1'b0);
      step();
    end
    idle_inputs();
    chk("full_throttle", saw_low, 1);
    wait_drain();

    // Both ports mispredict: port 0 recovers, PHT held off for that cycle.
    set_br(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1);
    step();
    idle_inputs();
    @(negedge clk);
    chk("rcv_pulse", {rcv_valid_o, rcv_bhr_o, rcv_taken_o}, {1'b1, 8'hA5, 1'b1});
    chk("rcv_we_off", pht_we_o, 0);
    @(negedge clk);
    chk("post_rcv", {rcv_valid_o, pht_we_o, pht_widx_o}, {1'b0, 1'b1, 8'hA5});
    step();
    wait_drain();

    // Queue at least six updates, then flush.
    for (int i = 0; i < 20 && exp_q.size() < 6; i++) begin
      set_br(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b1, 8'($urandom), 1'($urandom), 1'b0);
      step();
    end
    idle_inputs();
    chk("flush_fill", 32'(exp_q.size() >= 6), 1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_no_we", pht_we_o, 0);
      chk("flush_busy", busy_o, 0);
    end
    step();

    // Reset while draining.
    for (int i = 0; i < 4; i++) begin
      set_br(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b1, 8'($urandom), 1'($urandom), 1'b0);
      step();
    end
    idle_inputs();
    rst = 1'b1;
    exp_q.delete();
    rcv_q.delete();
    exp_sweep = 0;
    n_trained = 0;
    n_rcv = 0;
    #1;
    chk("rst_outputs", {pht_we_o, pht_init_o, rcv_valid_o, br0_ready_o, br1_ready_o, busy_o}, 6'b000001);
    chk("rst_widx", pht_widx_o, 0);
    step();
    step();
    rst = 1'b0;
    wait_sweep();

    // Random traffic with occasional mispredicts and flushes.
    for (int i = 0; i < 400; i++) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      set_br(v0, 8'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
             v1, 8'($urandom), 1'($urandom), $urandom_range(0, 5) == 0);
      flush_i = !v0 && !v1 && ($urandom_range(0, 29) == 0);
      step();
    end
    idle_inputs();
    wait_drain();

`ifdef BP_UPD_SCHED_STATS_EN
    chk("stat_upd", stat_upd_o, n_trained);
    chk("stat_mis", stat_mis_o, n_rcv);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
